distram_2: RTL and testbench



---
 rtl/distram_2.sv | 31 +++
 tb/tb_distram_2.sv | 114 +++++++++++
 2 files changed

// File: rtl/distram_2.sv
// distram_2: 8192x31 cache tag RAM, sync write, async read, per-entry written flags cleared by rst_n; DISTRAM2_REG_OUT_EN registers dout
module distram_2 #(
  parameter int AW = 13,
  parameter int DW = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  input  logic          we
);
  logic [DW-1:0]    mem [2**AW];
  logic [2**AW-1:0] wr_flag;
  logic [DW-1:0]    rd;
  always_ff @(posedge clk)
    if (we && rst_n) mem[addr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_flag <= '0;
    else if (we) wr_flag[addr] <= 1'b1;
  assign rd = wr_flag[addr] ? mem[addr] : '0;
`ifdef DISTRAM2_REG_OUT_EN
  logic [DW-1:0] dout_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout_q <= '0;
    else dout_q <= rd;
  assign dout = dout_q;
`else
  assign dout = rd;
`endif
endmodule

// File: tb/tb_distram_2.sv
// tb_distram_2: randomized check of distram_2 against an array model plus literal spot checks
module tb_distram_2;
  localparam int AW = 13, DW = 31, N = 2**AW;
  logic clk = 0, rst_n = 1, we = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0, dout;
  logic [DW-1:0] m_mem [N];
  bit m_flag [N];
  logic [DW-1:0] m_q = '0;
  int checks = 0, errors = 0;
  bit en = 0;

  distram_2 #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .dout(dout), .we(we));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    return m_flag[a] ? m_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] m_exp();
`ifdef DISTRAM2_REG_OUT_EN
    return m_q;
`else
    return m_rd(addr);
`endif
  endfunction

  always @(negedge rst_n) begin
    foreach (m_flag[i]) m_flag[i] = 0;
    m_q = '0;
  end

  always @(posedge clk)
    if (rst_n) begin
      m_q = m_rd(addr);
      if (we) begin
        m_mem[addr] = din;
        m_flag[addr] = 1;
      end
    end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: addr=%h dout=%h expected=%h", name, addr, act, exp);
    end
  endtask

  always @(negedge clk)
    if (en) check("model", dout, m_exp());

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    @(posedge clk); #1 addr = a; we = 0;
    #2 check(name, dout, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1 addr = a; din = d; we = 1;
    @(posedge clk); #1 we = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #2 en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rd(13'h0000, '0, "rst_a0");
    rd(13'h1000, '0, "rst_a1000");
    rd(13'h1FFF, '0, "rst_a1fff");
`ifndef DISTRAM2_REG_OUT_EN
    wr(13'h0ABC, 31'h7FFF_FFFF);
    #2 check("wr_abc", dout, 31'h7FFF_FFFF);
    rd(13'h0ABB, '0, "nb_abb");
    rd(13'h0ABD, '0, "nb_abd");
    rd(13'h0ABC, 31'h7FFF_FFFF, "rd_abc");
    wr(13'h0005, 31'h1234_5678);
    din = 31'h0000_0001; we = 1;
    #2 check("rdw_before", dout, 31'h1234_5678);
    @(posedge clk); #1 we = 0;
    #2 check("rdw_after", dout, 31'h0000_0001);
    @(posedge clk); #1 addr = 13'h0100; din = 31'h5555_5555; we = 0;
    @(posedge clk); #2 check("we0_hold", dout, '0);
    wr(13'h1FFF, 31'h0000_ABCD);
    #2 check("wr_1fff", dout, 31'h0000_ABCD);
    #1 rst_n = 0;
    #1 check("rst_mid", dout, '0);
    @(posedge clk); #1 rst_n = 1;
    #2 check("rst_hidden", dout, '0);
    wr(13'h1FFF, 31'h11);
    #2 check("rewrite", dout, 31'h11);
`else
    wr(13'h0042, 31'h2AAA_AAAA);
    #2 check("reg_e0", dout, '0);
    @(posedge clk); #1 check("reg_e1", dout, 31'h2AAA_AAAA);
    rst_n = 0;
    #1 check("reg_rst", dout, '0);
    @(posedge clk); #1 rst_n = 1;
    #2 check("reg_rst_hold", dout, '0);
`endif
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1
      addr = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      din = DW'($urandom);
      we = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 150) != 0);
    end
    @(posedge clk); #1 rst_n = 1; we = 0;
    @(posedge clk); #1 en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
